// File: rtl/iob_cache_fe_arbiter_pkg.sv
// ============================================================================
// Module : iob_cache_fe_arbiter_pkg
// Brief  : Shared FSM encodings and helpers for the cache front-end arbiter.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package iob_cache_fe_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_REQ  = 2'd1;
  localparam logic [1:0] ARB_RESP = 2'd2;

  // Port-select width; a single port still needs a 1-bit index.
  function automatic int sel_w(input int nports);
    return (nports > 1) ? $clog2(nports) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iob_cache_arb_rr.sv
// ============================================================================
// Module : iob_cache_arb_rr
// Brief  : Combinational round-robin priority encoder starting at ptr.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module iob_cache_arb_rr
  import iob_cache_fe_arbiter_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int SEL_W  = sel_w(NPORTS)
) (
  input  logic [NPORTS-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  grant,
  output logic              any
);

  // Walk offsets from farthest to nearest so the port closest to ptr wins.
  always_comb begin
    grant = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      for (int p = 0; p < NPORTS; p++) begin
        if (req[p] && (p == ((int'(ptr) + i) % NPORTS))) begin
          grant = SEL_W'(p);
        end
      end
    end
  end

  assign any = |req;

endmodule

`default_nettype wire

// File: rtl/iob_cache_fe_arbiter.sv
// ============================================================================
// Module : iob_cache_fe_arbiter
// Brief  : N-port round-robin IOb arbiter in front of the cache front end.
//          Optional per-port grant counters with IOB_CACHE_ARB_CNT_EN.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module iob_cache_fe_arbiter
  import iob_cache_fe_arbiter_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       arst_n_i,
  input  logic [NPORTS-1:0]          fe_avalid_i,
  input  logic [NPORTS*ADDR_W-1:0]   fe_addr_i,
  input  logic [NPORTS*DATA_W-1:0]   fe_wdata_i,
  input  logic [NPORTS*DATA_W/8-1:0] fe_wstrb_i,
  output logic [NPORTS-1:0]          fe_ready_o,
  output logic [NPORTS-1:0]          fe_rvalid_o,
  output logic [NPORTS*DATA_W-1:0]   fe_rdata_o,
  output logic                       c_avalid_o,
  output logic [ADDR_W-1:0]          c_addr_o,
  output logic [DATA_W-1:0]          c_wdata_o,
  output logic [DATA_W/8-1:0]        c_wstrb_o,
  input  logic                       c_ready_i,
  input  logic                       c_rvalid_i,
`ifdef IOB_CACHE_ARB_CNT_EN
  input  logic                       cnt_rst_i,
  output logic [NPORTS*CNT_W-1:0]    grant_cnt_o,
`endif
  input  logic [DATA_W-1:0]          c_rdata_i
);

  localparam int               SEL_W     = sel_w(NPORTS);
  localparam int               STRB_W    = DATA_W / 8;
  localparam logic [SEL_W-1:0] LAST_PORT = SEL_W'(NPORTS - 1);

  if (NPORTS < 1 || NPORTS > 16 || (DATA_W % 8) != 0 || ADDR_W < 1 || CNT_W < 1) begin : g_param_check
    $error("iob_cache_fe_arbiter: illegal parameter set");
  end

  logic [1:0]       r_state;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_ptr;

  logic [SEL_W-1:0]  w_grant;
  logic              w_any;
  logic              w_in_req;
  logic              w_in_resp;
  logic              w_sel_avalid;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [STRB_W-1:0] w_sel_wstrb;
  logic              w_accept;
  logic              w_is_write;
  logic [SEL_W-1:0]  w_ptr_next;

  iob_cache_arb_rr #(
    .NPORTS (NPORTS),
    .SEL_W  (SEL_W)
  ) u_rr (
    .req   (fe_avalid_i),
    .ptr   (r_ptr),
    .grant (w_grant),
    .any   (w_any)
  );

  always_comb begin
    w_sel_avalid = 1'b0;
    w_sel_addr   = '0;
    w_sel_wdata  = '0;
    w_sel_wstrb  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (r_sel == SEL_W'(p)) begin
        w_sel_avalid = fe_avalid_i[p];
        w_sel_addr   = fe_addr_i[p*ADDR_W +: ADDR_W];
        w_sel_wdata  = fe_wdata_i[p*DATA_W +: DATA_W];
        w_sel_wstrb  = fe_wstrb_i[p*STRB_W +: STRB_W];
      end
    end
  end

  assign w_in_req   = (r_state == ARB_REQ);
  assign w_in_resp  = (r_state == ARB_RESP);
  assign w_accept   = c_avalid_o & c_ready_i;
  assign w_is_write = |w_sel_wstrb;
  assign w_ptr_next = (r_sel == LAST_PORT) ? '0 : r_sel + 1'b1;

  // Cache side is driven only while a request is being presented.
  assign c_avalid_o = w_in_req & w_sel_avalid;
  assign c_addr_o   = w_in_req ? w_sel_addr  : '0;
  assign c_wdata_o  = w_in_req ? w_sel_wdata : '0;
  assign c_wstrb_o  = w_in_req ? w_sel_wstrb : '0;

  always_comb begin
    fe_ready_o  = '0;
    fe_rvalid_o = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (r_sel == SEL_W'(p)) begin
        fe_ready_o[p]  = w_in_req & c_ready_i;
        fe_rvalid_o[p] = w_in_resp & c_rvalid_i;
      end
    end
  end

  // Read data is broadcast; fe_rvalid_o alone tells the owner it is meant for it.
  assign fe_rdata_o = w_in_resp ? {NPORTS{c_rdata_i}} : '0;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= ARB_IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_sel   <= w_grant;
            r_state <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (w_accept) begin
            if (w_is_write) begin
              r_state <= ARB_IDLE;
              r_ptr   <= w_ptr_next;
            end else begin
              r_state <= ARB_RESP;
            end
          end else if (!w_sel_avalid) begin
            // Master withdrew its request: abandon without moving the pointer.
            r_state <= ARB_IDLE;
          end
        end
        ARB_RESP: begin
          if (c_rvalid_i) begin
            r_state <= ARB_IDLE;
            r_ptr   <= w_ptr_next;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

`ifdef IOB_CACHE_ARB_CNT_EN
  for (genvar p = 0; p < NPORTS; p++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
        r_cnt <= '0;
      end else if (cnt_rst_i) begin
        r_cnt <= '0;
      end else if (w_accept && (r_sel == SEL_W'(p)) && !(&r_cnt)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign grant_cnt_o[p*CNT_W +: CNT_W] = r_cnt;
  end
`endif

endmodule

`default_nettype wire
